// File: rtl/shift_arbiter.sv
// shift_arbiter: two-port arbiter in front of a single shared 32-bit barrel
// shifter, with a one-entry registered result stage.
//
// Ports:
//   clk, rst_n                   clock (rising edge), async active-low reset
//   pN_valid / pN_ready          request handshake for port N (N = 0, 1)
//   pN_in, pN_dir, pN_by,        operand, direction (1 = left), amount,
//   pN_arith                     arithmetic-right enable
//   res_valid / res_ready        result handshake
//   res_out, res_src             registered result and issuing port
//
// mshifter32: combinational 32-bit shifter (left, logical right,
// arithmetic right). Arith is ignored for left shifts.

module mshifter32 (
    input  logic [31:0] operand,
    input  logic        dir,
    input  logic [4:0]  by,
    input  logic        arith,
    output logic [31:0] result
);
    always_comb begin
        result = '0;
        if (dir) begin
            result = operand << by;
        end else if (arith) begin
            result = $unsigned($signed(operand) >>> by);
        end else begin
            result = operand >> by;
        end
    end
endmodule

module shift_arbiter #(
    parameter int unsigned RR_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_valid,
    output logic        p0_ready,
    input  logic [31:0] p0_in,
    input  logic        p0_dir,
    input  logic [4:0]  p0_by,
    input  logic        p0_arith,
    input  logic        p1_valid,
    output logic        p1_ready,
    input  logic [31:0] p1_in,
    input  logic        p1_dir,
    input  logic [4:0]  p1_by,
    input  logic        p1_arith,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_out,
    output logic        res_src
);
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]  state_q, state_d;
    logic        ptr_q, ptr_d;
    logic [31:0] res_out_q, res_out_d;
    logic        res_src_q, res_src_d;

    logic        accept;
    logic        favour1;
    logic        gnt0, gnt1;

    logic [31:0] sh_operand;
    logic        sh_dir;
    logic [4:0]  sh_by;
    logic        sh_arith;
    logic [31:0] sh_result;

    // Grants use only valids, pointer, state and res_ready, so there is no
    // path from operand data to either ready. Gated by rst_n so readys stay
    // low for the whole reset.
    always_comb begin
        accept  = (state_q == ST_EMPTY) || res_ready;
        favour1 = (RR_EN != 0) && ptr_q;
        gnt0    = rst_n && accept && p0_valid && (!p1_valid || !favour1);
        gnt1    = rst_n && accept && p1_valid && (!p0_valid ||  favour1);
    end

    assign p0_ready = gnt0;
    assign p1_ready = gnt1;

    // Shared shifter is steered by the grant; when nothing is granted the
    // result is simply not captured.
    always_comb begin
        if (gnt1) begin
            sh_operand = p1_in;
            sh_dir     = p1_dir;
            sh_by      = p1_by;
            sh_arith   = p1_arith;
        end else begin
            sh_operand = p0_in;
            sh_dir     = p0_dir;
            sh_by      = p0_by;
            sh_arith   = p0_arith;
        end
    end

    mshifter32 u_shifter (
        .operand (sh_operand),
        .dir     (sh_dir),
        .by      (sh_by),
        .arith   (sh_arith),
        .result  (sh_result)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        res_out_d = res_out_q;
        res_src_d = res_src_q;
        if (gnt0 || gnt1) begin
            state_d   = ST_FULL;
            res_out_d = sh_result;
            res_src_d = gnt1;
            // Pointer moves to the port that lost (or was idle).
            ptr_d     = gnt0;
        end else if (state_q == ST_FULL && res_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            ptr_q     <= 1'b0;
            res_out_q <= '0;
            res_src_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            res_out_q <= res_out_d;
            res_src_q <= res_src_d;
        end
    end

    assign res_valid = (state_q == ST_FULL);
    assign res_out   = res_out_q;
    assign res_src   = res_src_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model. A second instance with
// fixed priority shares the inputs.

module tb_shift_arbiter;
    logic        clk;
    logic        rst_n;
    logic        p0_valid, p1_valid;
    logic [31:0] p0_in, p1_in;
    logic        p0_dir, p1_dir;
    logic [4:0]  p0_by, p1_by;
    logic        p0_arith, p1_arith;
    logic        res_ready;

    logic        p0_ready, p1_ready, res_valid, res_src;
    logic [31:0] res_out;
    logic        fp_p0_ready, fp_p1_ready, fp_res_valid, fp_res_src;
    logic [31:0] fp_res_out;

    int checks = 0;
    int errors = 0;

    shift_arbiter #(.RR_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_in(p0_in),
        .p0_dir(p0_dir), .p0_by(p0_by), .p0_arith(p0_arith),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_in(p1_in),
        .p1_dir(p1_dir), .p1_by(p1_by), .p1_arith(p1_arith),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_out(res_out), .res_src(res_src)
    );

    shift_arbiter #(.RR_EN(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .p0_valid(p0_valid), .p0_ready(fp_p0_ready), .p0_in(p0_in),
        .p0_dir(p0_dir), .p0_by(p0_by), .p0_arith(p0_arith),
        .p1_valid(p1_valid), .p1_ready(fp_p1_ready), .p1_in(p1_in),
        .p1_dir(p1_dir), .p1_by(p1_by), .p1_arith(p1_arith),
        .res_valid(fp_res_valid), .res_ready(res_ready),
        .res_out(fp_res_out), .res_src(fp_res_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference shift: right arithmetic is built as logical shift plus a
    // mask of sign bits over the vacated positions.
    function automatic logic [31:0] ref_shift(logic [31:0] v, logic d,
                                              logic [4:0] b, logic a);
        logic [31:0] keep;
        if (d) return v << b;
        keep = 32'hFFFF_FFFF >> b;
        if (a && v[31]) return (v >> b) | ~keep;
        return v >> b;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p0(logic v, logic [31:0] d, logic dr, logic [4:0] b, logic a);
        p0_valid = v; p0_in = d; p0_dir = dr; p0_by = b; p0_arith = a;
    endtask

    task automatic set_p1(logic v, logic [31:0] d, logic dr, logic [4:0] b, logic a);
        p1_valid = v; p1_in = d; p1_dir = dr; p1_by = b; p1_arith = a;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        res_ready = 1'b1;
        set_p0(1'b1, 32'h1234_5678, 1'b0, 5'd3, 1'b0);
        set_p1(1'b1, 32'h8765_4321, 1'b1, 5'd4, 1'b0);
        cycle();
        cycle();
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        checks++;
        if (res_out !== 32'h0) begin errors++; $display("FAIL reset_res_out: got %h want 00000000", res_out); end
        checks++;
        if (res_src !== 1'b0) begin errors++; $display("FAIL reset_res_src: got %b want 0", res_src); end
        checks++;
        if ({p0_ready, p1_ready} !== 2'b00) begin errors++; $display("FAIL reset_readys: got %b want 00", {p0_ready, p1_ready}); end
        set_p0(1'b0, '0, 1'b0, '0, 1'b0);
        set_p1(1'b0, '0, 1'b0, '0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic test_single_p0();
        set_p0(1'b1, 32'h8000_0001, 1'b0, 5'd1, 1'b1);
        res_ready = 1'b1;
        #1;
        checks++;
        if ({p0_ready, p1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready: got %b want 10", {p0_ready, p1_ready}); end
        cycle();
        set_p0(1'b0, '0, 1'b0, '0, 1'b0);
        checks++;
        if (res_valid !== 1'b1 || res_out !== 32'hC000_0000 || res_src !== 1'b0) begin
            errors++;
            $display("FAIL single_result: got v=%b out=%h src=%b want v=1 out=c0000000 src=0", res_valid, res_out, res_src);
        end
        cycle();
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b want 0", res_valid); end
    endtask

    task automatic test_boundary();
        logic [31:0] vin [3] = '{32'h0000_0001, 32'h0000_0001, 32'h8000_0000};
        logic        vdir[3] = '{1'b1, 1'b1, 1'b0};
        logic [4:0]  vby [3] = '{5'd31, 5'd0, 5'd31};
        logic        var_[3] = '{1'b0, 1'b0, 1'b1};
        logic [31:0] vexp[3] = '{32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_p1(1'b1, vin[i], vdir[i], vby[i], var_[i]);
            cycle();
            checks++;
            if (res_valid !== 1'b1 || res_out !== vexp[i] || res_src !== 1'b1) begin
                errors++;
                $display("FAIL boundary_%0d: got v=%b out=%h src=%b want v=1 out=%h src=1", i, res_valid, res_out, res_src, vexp[i]);
            end
        end
        set_p1(1'b0, '0, 1'b0, '0, 1'b0);
        cycle();
    endtask

    // Last grant was p1, so the round-robin pointer favours p0 here.
    task automatic test_round_robin();
        logic exp_src;
        res_ready = 1'b1;
        set_p0(1'b1, 32'hAAAA_0000, 1'b1, 5'd0, 1'b0);
        set_p1(1'b1, 32'h0000_5555, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            exp_src = (i % 2 == 1);
            #1;
            checks++;
            if ({p0_ready, p1_ready} !== {!exp_src, exp_src}) begin
                errors++;
                $display("FAIL rr_ready_%0d: got %b want %b", i, {p0_ready, p1_ready}, {!exp_src, exp_src});
            end
            checks++;
            if ({fp_p0_ready, fp_p1_ready} !== 2'b10) begin
                errors++;
                $display("FAIL fp_ready_%0d: got %b want 10", i, {fp_p0_ready, fp_p1_ready});
            end
            @(posedge clk);
            #1;
            checks++;
            if (res_src !== exp_src || res_out !== (exp_src ? 32'h0000_5555 : 32'hAAAA_0000)) begin
                errors++;
                $display("FAIL rr_result_%0d: got src=%b out=%h want src=%b", i, res_src, res_out, exp_src);
            end
            checks++;
            if (fp_res_src !== 1'b0 || fp_res_out !== 32'hAAAA_0000) begin
                errors++;
                $display("FAIL fp_result_%0d: got src=%b out=%h want src=0 out=aaaa0000", i, fp_res_src, fp_res_out);
            end
        end
        set_p0(1'b0, '0, 1'b0, '0, 1'b0);
        set_p1(1'b0, '0, 1'b0, '0, 1'b0);
        cycle();
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        res_ready = 1'b0;
        set_p0(1'b1, 32'h0F0F_0F0F, 1'b1, 5'd4, 1'b0);
        cycle();
        set_p0(1'b0, '0, 1'b0, '0, 1'b0);
        held = 32'hF0F0_F0F0;
        set_p1(1'b1, 32'hF000_0000, 1'b0, 5'd8, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({p0_ready, p1_ready} !== 2'b00) begin
                errors++;
                $display("FAIL bp_ready_%0d: got %b want 00", i, {p0_ready, p1_ready});
            end
            cycle();
            checks++;
            if (res_valid !== 1'b1 || res_out !== held || res_src !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: got v=%b out=%h src=%b want v=1 out=%h src=0", i, res_valid, res_out, res_src, held);
            end
        end
        res_ready = 1'b1;
        #1;
        checks++;
        if (p1_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", p1_ready); end
        cycle();
        set_p1(1'b0, '0, 1'b0, '0, 1'b0);
        checks++;
        if (res_valid !== 1'b1 || res_out !== 32'hFFF0_0000 || res_src !== 1'b1) begin
            errors++;
            $display("FAIL bp_no_bubble: got v=%b out=%h src=%b want v=1 out=fff00000 src=1", res_valid, res_out, res_src);
        end
    endtask

    task automatic test_async_reset();
        // Grant p0 alone so the pointer favours p1 before reset; stay FULL.
        res_ready = 1'b1;
        set_p0(1'b1, 32'h0000_00FF, 1'b1, 5'd8, 1'b0);
        cycle();
        set_p0(1'b0, '0, 1'b0, '0, 1'b0);
        res_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (res_valid !== 1'b0 || res_out !== 32'h0 || res_src !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_clear: got v=%b out=%h src=%b want v=0 out=0 src=0", res_valid, res_out, res_src);
        end
        set_p0(1'b1, 32'h1111_1111, 1'b1, 5'd0, 1'b0);
        set_p1(1'b1, 32'h2222_2222, 1'b1, 5'd0, 1'b0);
        #1;
        checks++;
        if ({p0_ready, p1_ready} !== 2'b00) begin errors++; $display("FAIL async_reset_ready: got %b want 00", {p0_ready, p1_ready}); end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        checks++;
        if ({p0_ready, p1_ready} !== 2'b10) begin errors++; $display("FAIL async_first_grant: got %b want 10", {p0_ready, p1_ready}); end
        @(posedge clk);
        #1;
        set_p0(1'b0, '0, 1'b0, '0, 1'b0);
        set_p1(1'b0, '0, 1'b0, '0, 1'b0);
        checks++;
        if (res_valid !== 1'b1 || res_src !== 1'b0 || res_out !== 32'h1111_1111) begin
            errors++;
            $display("FAIL async_first_result: got v=%b out=%h src=%b want v=1 out=11111111 src=0", res_valid, res_out, res_src);
        end
        res_ready = 1'b1;
        cycle();
    endtask

    task automatic test_random();
        logic        pv  [2];
        logic [31:0] pin [2];
        logic        pdir[2];
        logic [4:0]  pby [2];
        logic        par [2];
        logic        m_full, m_src, m_ptr;
        logic [31:0] m_out;
        logic        acc, g0, g1, win;

        rst_n = 1'b0;
        set_p0(1'b0, '0, 1'b0, '0, 1'b0);
        set_p1(1'b0, '0, 1'b0, '0, 1'b0);
        #3;
        rst_n = 1'b1;
        cycle();
        m_full = 1'b0; m_src = 1'b0; m_ptr = 1'b0; m_out = '0;
        pv[0] = 1'b0; pv[1] = 1'b0;

        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pv[k] && ($urandom % 10) < 6) begin
                    pv[k]   = 1'b1;
                    pin[k]  = $urandom;
                    pdir[k] = $urandom_range(0, 1) != 0;
                    pby[k]  = 5'($urandom_range(0, 31));
                    par[k]  = $urandom_range(0, 1) != 0;
                end
            end
            set_p0(pv[0], pin[0], pdir[0], pby[0], par[0]);
            set_p1(pv[1], pin[1], pdir[1], pby[1], par[1]);
            res_ready = ($urandom % 4) != 0;
            #1;

            // Reference arbitration: one request -> it wins; two -> pointer.
            acc = !m_full || res_ready;
            g0 = 1'b0; g1 = 1'b0;
            if (acc) begin
                if (pv[0] && pv[1]) begin
                    if (m_ptr) g1 = 1'b1; else g0 = 1'b1;
                end else begin
                    g0 = pv[0];
                    g1 = pv[1];
                end
            end
            checks++;
            if ({p0_ready, p1_ready} !== {g0, g1}) begin
                errors++;
                $display("FAIL rand_ready_%0d: got %b want %b", i, {p0_ready, p1_ready}, {g0, g1});
            end

            @(posedge clk);
            if (g0 || g1) begin
                win    = g1;
                m_full = 1'b1;
                m_src  = win;
                m_out  = ref_shift(pin[win], pdir[win], pby[win], par[win]);
                m_ptr  = !win;
                pv[win] = 1'b0;
            end else if (m_full && res_ready) begin
                m_full = 1'b0;
            end
            #1;
            checks++;
            if (res_valid !== m_full) begin
                errors++;
                $display("FAIL rand_valid_%0d: got %b want %b", i, res_valid, m_full);
            end
            if (m_full) begin
                checks++;
                if (res_out !== m_out || res_src !== m_src) begin
                    errors++;
                    $display("FAIL rand_result_%0d: got out=%h src=%b want out=%h src=%b", i, res_out, res_src, m_out, m_src);
                end
            end
        end
        set_p0(1'b0, '0, 1'b0, '0, 1'b0);
        set_p1(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        test_reset();
        cycle();
        test_single_p0();
        test_boundary();
        test_round_robin();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
